// File: rtl/mips_wb_queue.sv
// mips_wb_queue
// In-order write-back queue feeding the MIPS register-file write port.
// Completed results are buffered in a circular FIFO and retired one per
// cycle (unless hold is asserted). A combinational lookup reports whether
// any queued entry targets a given register so decode can detect RAW hazards.
// Writes to $0 are accepted and silently discarded.
//
// Optional feature macro: FORWARD_EN
//   When defined, an extra output lk_data returns the data of the youngest
//   queued entry targeting lk_regnum (0 when none), letting decode bypass
//   instead of stalling. When undefined the port and its data mux are absent.

module mips_wb_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_regnum,
    input  logic [WIDTH-1:0] in_data,
    input  logic             hold,
    output logic [4:0]       wr_regnum,
    output logic [WIDTH-1:0] wr_data,
    output logic             writeenable,
    input  logic [4:0]       lk_regnum,
    output logic             lk_pending
`ifdef FORWARD_EN
    ,
    output logic [WIDTH-1:0] lk_data
`endif
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Entry storage, one slot per FIFO position.
    logic [4:0]       r_regnum [DEPTH];
    logic [WIDTH-1:0] r_data   [DEPTH];

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_empty;

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_match;

    assign w_empty  = (r_count == '0);

    // Ready depends on occupancy only: a retire in the same cycle does not
    // make room until the following cycle.
    assign in_ready = (r_count != CW'(DEPTH));

    // Handshake completes for any offered result; only non-$0 results
    // actually occupy a slot.
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & (in_regnum != 5'd0);

    // Retire the head entry whenever one exists and the port is free.
    assign w_pop       = ~w_empty & ~hold;
    assign writeenable = w_pop;
    assign wr_regnum   = w_empty ? 5'd0 : r_regnum[r_head];
    assign wr_data     = w_empty ? '0   : r_data[r_head];

    // Per-slot occupancy and register match for the hazard lookup. A slot
    // is valid when its distance from head is below the occupancy count;
    // the head slot stays valid during the cycle it is retiring.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PW-1:0] w_age;
            assign w_age       = PW'(gi) - r_head;
            assign w_valid[gi] = ({1'b0, w_age} < r_count);
            assign w_match[gi] = w_valid[gi] & (r_regnum[gi] == lk_regnum);
        end
    endgenerate

    assign lk_pending = (lk_regnum != 5'd0) & (|w_match);

`ifdef FORWARD_EN
    // Walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx   = '0;
        lk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            v_idx = r_head + PW'(k);
            if (w_match[v_idx]) begin
                lk_data = r_data[v_idx];
            end
        end
        if (lk_regnum == 5'd0) begin
            lk_data = '0;
        end
    end
`endif

    // Entry payload write at the tail; storage needs no reset because
    // occupancy is tracked separately by the pointers and count.
    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_regnum[r_tail] <= in_regnum;
            r_data[r_tail]   <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset overrides any push or pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_wb_queue.sv
// Directed testbench for mips_wb_queue (DEPTH=4, WIDTH=32).
// Inputs are driven 1 time unit after the rising edge and outputs are
// checked 1 unit later, well away from the next active edge.

`timescale 1ns/1ps

module tb_mips_wb_queue;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_regnum;
    logic [31:0] in_data;
    logic        hold;
    logic [4:0]  wr_regnum;
    logic [31:0] wr_data;
    logic        writeenable;
    logic [4:0]  lk_regnum;
    logic        lk_pending;
`ifdef FORWARD_EN
    logic [31:0] lk_data;
`endif

    int checks = 0;
    int errors = 0;

    mips_wb_queue #(.DEPTH(4), .WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_regnum   (in_regnum),
        .in_data     (in_data),
        .hold        (hold),
        .wr_regnum   (wr_regnum),
        .wr_data     (wr_data),
        .writeenable (writeenable),
        .lk_regnum   (lk_regnum),
        .lk_pending  (lk_pending)
`ifdef FORWARD_EN
        ,
        .lk_data     (lk_data)
`endif
    );

    always #5 clock = ~clock;

    // Advance one clock edge and step just past it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_regnum = '0; in_data = '0;
        hold = 1'b0; lk_regnum = 5'd5;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", writeenable); end
        checks++; if (wr_regnum !== 5'd0) begin errors++; $display("FAIL reset_wr_regnum got %0d want 0", wr_regnum); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (lk_pending !== 1'b0) begin errors++; $display("FAIL reset_lk_pending got %b want 0", lk_pending); end
        $display("reset: in_ready=%b we=%b", in_ready, writeenable);
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_regnum = 5'd5; in_data = 32'hDEADBEEF; hold = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; lk_regnum = 5'd5;
        #1;
        checks++; if (writeenable !== 1'b1) begin errors++; $display("FAIL single_we got %b want 1", writeenable); end
        checks++; if (wr_regnum !== 5'd5) begin errors++; $display("FAIL single_regnum got %0d want 5", wr_regnum); end
        checks++; if (wr_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data got %h want deadbeef", wr_data); end
        checks++; if (lk_pending !== 1'b1) begin errors++; $display("FAIL single_lk_head got %b want 1", lk_pending); end
        tick();
        #1;
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL single_we_after got %b want 0", writeenable); end
        checks++; if (wr_regnum !== 5'd0) begin errors++; $display("FAIL single_regnum_after got %0d want 0", wr_regnum); end
        $display("single: r5 <= deadbeef retired");
    endtask

    task automatic test_full_hold();
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_regnum = 5'(i); in_data = 32'(i);
            tick();
        end
        in_valid = 1'b0; lk_regnum = 5'd3;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", in_ready); end
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL full_hold_we got %b want 0", writeenable); end
        checks++; if (lk_pending !== 1'b1) begin errors++; $display("FAIL full_lk3 got %b want 1", lk_pending); end
        lk_regnum = 5'd9;
        #1;
        checks++; if (lk_pending !== 1'b0) begin errors++; $display("FAIL full_lk9 got %b want 0", lk_pending); end
        // Offer r9 while full and retiring: it must not be accepted.
        hold = 1'b0; in_valid = 1'b1; in_regnum = 5'd9; in_data = 32'h99;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (writeenable !== 1'b1) begin errors++; $display("FAIL drain_we%0d got %b want 1", k, writeenable); end
            checks++; if (wr_regnum !== 5'(k)) begin errors++; $display("FAIL drain_regnum%0d got %0d want %0d", k, wr_regnum, k); end
            checks++; if (wr_data !== 32'(k)) begin errors++; $display("FAIL drain_data%0d got %h want %h", k, wr_data, k); end
            if (k == 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_retire_ready got %b want 0", in_ready); end
                tick();
                in_valid = 1'b0;
            end else begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_ready%0d got %b want 1", k, in_ready); end
                tick();
            end
            $display("drain: retired r%0d", k);
        end
        #1;
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL drain_empty_we got %b want 0", writeenable); end
    endtask

    task automatic test_zero_reg();
        in_valid = 1'b1; in_regnum = 5'd0; in_data = 32'h1234; hold = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0; lk_regnum = 5'd0;
        #1;
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL zero_we got %b want 0", writeenable); end
        checks++; if (lk_pending !== 1'b0) begin errors++; $display("FAIL zero_lk got %b want 0", lk_pending); end
        checks++; if (wr_data !== 32'd0) begin errors++; $display("FAIL zero_data got %h want 0", wr_data); end
        $display("zero: r0 write discarded");
    endtask

    task automatic test_same_reg();
        hold = 1'b1;
        in_valid = 1'b1; in_regnum = 5'd7; in_data = 32'hAAAA_0001; tick();
        in_regnum = 5'd7; in_data = 32'hBBBB_0002; tick();
        in_valid = 1'b0; lk_regnum = 5'd7;
        #1;
        checks++; if (lk_pending !== 1'b1) begin errors++; $display("FAIL same_lk got %b want 1", lk_pending); end
`ifdef FORWARD_EN
        checks++; if (lk_data !== 32'hBBBB_0002) begin errors++; $display("FAIL same_fwd got %h want bbbb0002", lk_data); end
`endif
        hold = 1'b0;
        #1;
        checks++; if (wr_regnum !== 5'd7 || wr_data !== 32'hAAAA_0001 || writeenable !== 1'b1)
            begin errors++; $display("FAIL same_first got r%0d %h we=%b want r7 aaaa0001 1", wr_regnum, wr_data, writeenable); end
        tick();
        checks++; if (wr_regnum !== 5'd7 || wr_data !== 32'hBBBB_0002 || writeenable !== 1'b1)
            begin errors++; $display("FAIL same_second got r%0d %h we=%b want r7 bbbb0002 1", wr_regnum, wr_data, writeenable); end
        tick();
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL same_done got %b want 0", writeenable); end
        $display("same_reg: r7 A then B");
    endtask

    task automatic test_back_to_back();
        logic [4:0]  q_reg[$];
        logic [31:0] q_dat[$];
        logic [4:0]  r;
        logic [31:0] d;
        // Pre-fill two entries under hold, then push and retire every cycle.
        hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            r = 5'(i + 10); d = 32'hC000_0000 + 32'(i);
            in_valid = 1'b1; in_regnum = r; in_data = d;
            q_reg.push_back(r); q_dat.push_back(d);
            tick();
        end
        hold = 1'b0;
        for (int i = 0; i < 20; i++) begin
            r = 5'((i % 31) + 1); d = 32'h1000 + 32'(i);
            in_valid = 1'b1; in_regnum = r; in_data = d;
            #1;
            checks++; if (writeenable !== 1'b1 || wr_regnum !== q_reg[0] || wr_data !== q_dat[0] || in_ready !== 1'b1)
                begin errors++; $display("FAIL steady%0d got we=%b r%0d %h rdy=%b want 1 r%0d %h 1", i, writeenable, wr_regnum, wr_data, in_ready, q_reg[0], q_dat[0]); end
            $display("steady %0d: retire r%0d %h, push r%0d %h", i, q_reg[0], q_dat[0], r, d);
            tick();
            void'(q_reg.pop_front()); void'(q_dat.pop_front());
            q_reg.push_back(r); q_dat.push_back(d);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (writeenable !== 1'b1 || wr_regnum !== q_reg[0] || wr_data !== q_dat[0])
                begin errors++; $display("FAIL steady_drain%0d got we=%b r%0d %h want 1 r%0d %h", i, writeenable, wr_regnum, wr_data, q_reg[0], q_dat[0]); end
            tick();
            void'(q_reg.pop_front()); void'(q_dat.pop_front());
        end
        #1;
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL steady_empty got %b want 0", writeenable); end
    endtask

    task automatic test_reset_mid();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_regnum = 5'(20 + i); in_data = 32'(i);
            tick();
        end
        // Reset with a simultaneous push offered: reset must win.
        reset = 1'b1; in_regnum = 5'd25; in_data = 32'h55;
        tick();
        reset = 1'b0; in_valid = 1'b0; hold = 1'b0;
        #1;
        checks++; if (writeenable !== 1'b0) begin errors++; $display("FAIL rstmid_we got %b want 0", writeenable); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
        for (int i = 0; i < 32; i++) begin
            lk_regnum = 5'(i);
            #1;
            checks++; if (lk_pending !== 1'b0) begin errors++; $display("FAIL rstmid_lk%0d got %b want 0", i, lk_pending); end
        end
        $display("reset_mid: queue cleared");
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_hold();
        test_zero_reg();
        test_same_reg();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
